// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU instruction format, opcodes and sequencer state encoding
// Purpose: instruction width, opcode field layout, OPC_* codes, field accessors,
//          sequencer state type and default EXEC_CYCLES.
// Ports:   none (package).
package cpu_defs;

    localparam int INSTR_W = 11;
    localparam int OPC_W   = 3;
    localparam int OP_W    = 4;

    // Instruction layout: [10:8] opcode, [7:4] op1, [3:0] op2.
    // Opcodes 0, 6 and 7 are unassigned and make the sequencer halt.
    localparam logic [OPC_W-1:0] OPC_LOD = 3'd1;
    localparam logic [OPC_W-1:0] OPC_STO = 3'd2;
    localparam logic [OPC_W-1:0] OPC_ADD = 3'd3;
    localparam logic [OPC_W-1:0] OPC_SUB = 3'd4;
    localparam logic [OPC_W-1:0] OPC_JMP = 3'd5;

    localparam int EXEC_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    function automatic logic [OPC_W-1:0] GET_OPCODE(input logic [INSTR_W-1:0] w);
        return w[10:8];
    endfunction

    function automatic logic [OP_W-1:0] GET_OP1(input logic [INSTR_W-1:0] w);
        return w[7:4];
    endfunction

    function automatic logic [OP_W-1:0] GET_OP2(input logic [INSTR_W-1:0] w);
        return w[3:0];
    endfunction

    function automatic logic opc_known(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_LOD, OPC_STO, OPC_ADD, OPC_SUB, OPC_JMP: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// rtl/seq_prog_mem.sv - 256x11 program store with per-word written flags
// Purpose: synchronous-read program memory; written flags cleared by reset,
//          word contents are not reset.
// Ports:   clk, reset_n (sync, active low); we/waddr/wdata write port;
//          raddr read address; rdata/rwritten registered read word and flag.
module seq_prog_mem
    import cpu_defs::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [7:0]         waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [7:0]         raddr,
    output logic [INSTR_W-1:0] rdata,
    output logic               rwritten
);

    logic [INSTR_W-1:0] mem [256];
    logic [255:0]       written;
    logic               wr_hit;

    // A write to the address being read in the same cycle is forwarded so a
    // load immediately followed by a fetch sees the new word.
    assign wr_hit = we && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= wr_hit ? wdata : mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            written  <= '0;
            rwritten <= 1'b0;
        end else begin
            if (we) begin
                written[waddr] <= 1'b1;
            end
            rwritten <= written[raddr] | wr_hit;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program sequencer feeding instructions to cpu_top
// Purpose: loads a program, then single-steps or free-runs it, holding each
//          instruction for EXEC_CYCLES cycles. Optional breakpoint when
//          SEQ_BREAKPOINT_EN is defined.
// Ports:   clk, reset_n (sync, active low); prog_we/prog_addr/prog_wdata load
//          port; step_req, run controls; bp_en/bp_addr breakpoint;
//          instruction, instr_valid, pc to cpu_top; busy, step_done, halted,
//          bp_hit status.
module instr_sequencer
    import cpu_defs::*;
#(
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEF,
    parameter int PROG_DEPTH  = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               prog_we,
    input  logic [7:0]         prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               step_req,
    input  logic               run,
    input  logic               bp_en,
    input  logic [7:0]         bp_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [7:0]         pc,
    output logic               busy,
    output logic               step_done,
    output logic               halted,
    output logic               bp_hit
);

    localparam int               CNT_W    = $clog2(EXEC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES);
    localparam logic [7:0]       LAST_PC  = 8'(PROG_DEPTH - 1);

    seq_state_t         state, state_nxt;
    logic [7:0]         pc_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               step_mode, step_mode_nxt;
    logic               step_done_nxt, bp_hit_nxt;
    logic               bp_stop;
    logic [INSTR_W-1:0] rd_data;
    logic               rd_written;
    logic               mem_we;

    assign mem_we = prog_we && (state == IDLE || state == HALT);

    // Read address is the next pc so the word is already registered when
    // FETCH is entered, keeping FETCH to a single cycle.
    seq_prog_mem u_mem (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (mem_we),
        .waddr    (prog_addr),
        .wdata    (prog_wdata),
        .raddr    (pc_nxt),
        .rdata    (rd_data),
        .rwritten (rd_written)
    );

`ifdef SEQ_BREAKPOINT_EN
    assign bp_stop = !step_mode && bp_en && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr};
    assign bp_stop   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            cnt         <= '0;
            step_mode   <= 1'b0;
            step_done   <= 1'b0;
            bp_hit      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
            cnt         <= cnt_nxt;
            step_mode   <= step_mode_nxt;
            step_done   <= step_done_nxt;
            bp_hit      <= bp_hit_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instruction;
        cnt_nxt       = cnt;
        step_mode_nxt = step_mode;
        step_done_nxt = 1'b0;
        bp_hit_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (step_req || run) begin
                    state_nxt     = FETCH;
                    step_mode_nxt = step_req;
                end
            end
            FETCH: begin
                if (bp_stop) begin
                    state_nxt  = IDLE;
                    bp_hit_nxt = 1'b1;
                end else if (!rd_written || !opc_known(GET_OPCODE(rd_data))) begin
                    state_nxt = HALT;
                end else begin
                    instr_nxt = rd_data;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    pc_nxt        = (pc == LAST_PC) ? 8'd0 : pc + 8'd1;
                    step_done_nxt = step_mode;
                    if (pc == LAST_PC) begin
                        state_nxt = HALT;
                    end else if (step_mode || !run) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign instr_valid = (state == EXEC);
    assign busy        = (state == FETCH) || (state == EXEC);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
// Purpose: randomized programs checked against a behavioural program model;
//          breakpoint scenario selected by SEQ_BREAKPOINT_EN.
// Ports:   none (top-level bench).
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, prog_we, step_req, run, bp_en;
    logic [7:0]  prog_addr, bp_addr, pc;
    logic [10:0] prog_wdata, instruction;
    logic        instr_valid, busy, step_done, halted, bp_hit;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .step_req    (step_req),
        .run         (run),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .step_done   (step_done),
        .halted      (halted),
        .bp_hit      (bp_hit)
    );

    localparam int EXEC_N = 3;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [10:0] m_mem [256];
    bit          m_wr  [256];
    int          exp_q[$];
    int          tr_pc[$];
    int          tr_ins[$];
    int          tr_len[$];
    int          n_unstable = 0;
    int          n_step_done = 0;
    int          n_bp_hit = 0;
    bit          was_valid = 1'b0;
    logic [10:0] last_ins;
    logic [7:0]  last_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Trace of executed instructions: one entry per instr_valid run.
    always @(negedge clk) begin
        if (instr_valid) begin
            if (!was_valid || tr_len.size() == 0) begin
                tr_pc.push_back(int'(pc));
                tr_ins.push_back(int'(instruction));
                tr_len.push_back(1);
            end else begin
                if (instruction !== last_ins || pc !== last_pc) n_unstable++;
                tr_len[tr_len.size()-1] = tr_len[tr_len.size()-1] + 1;
            end
        end
        if (step_done) n_step_done++;
        if (bp_hit) n_bp_hit++;
        was_valid = instr_valid;
        last_ins  = instruction;
        last_pc   = pc;
    end

    function automatic logic [10:0] rand_word(input bit valid);
        logic [2:0] opc;
        int         k;
        if (valid) begin
            opc = 3'($urandom_range(1, 5));
        end else begin
            k   = $urandom_range(0, 2);
            opc = (k == 0) ? 3'd0 : (k == 1) ? 3'd6 : 3'd7;
        end
        return {opc, 8'($urandom)};
    endfunction

    function automatic bit model_ok(input int a);
        logic [10:0] w;
        w = m_mem[a];
        return m_wr[a] && (w[10:8] >= 3'd1) && (w[10:8] <= 3'd5);
    endfunction

    // Free-run from start: execute consecutive valid words, stop at an
    // unwritten/illegal word, after address 255, or at the breakpoint.
    task automatic model_run(input int start, input int bp, output int end_pc, output bit halt);
        int a;
        bit done;
        a = start;
        done = 1'b0;
        halt = 1'b0;
        end_pc = 0;
        exp_q.delete();
        while (!done) begin
            if (a == bp) begin
                end_pc = a;
                done = 1'b1;
            end else if (!model_ok(a)) begin
                halt = 1'b1;
                end_pc = a;
                done = 1'b1;
            end else begin
                exp_q.push_back(a);
                if (a == 255) begin
                    halt = 1'b1;
                    end_pc = 0;
                    done = 1'b1;
                end
                a++;
            end
        end
    endtask

    task automatic clr_trace();
        tr_pc.delete();
        tr_ins.delete();
        tr_len.delete();
        n_unstable = 0;
        n_step_done = 0;
        n_bp_hit = 0;
    endtask

    task automatic check_trace(input string tag);
        check({tag, "_count"}, tr_pc.size(), exp_q.size());
        for (int i = 0; i < tr_pc.size() && i < exp_q.size(); i++) begin
            check({tag, "_pc"}, tr_pc[i], exp_q[i]);
            check({tag, "_instr"}, tr_ins[i], m_mem[exp_q[i]]);
            check({tag, "_len"}, tr_len[i], EXEC_N);
        end
        check({tag, "_stable"}, n_unstable, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        prog_we = 1'b0;
        step_req = 1'b0;
        run = 1'b0;
        bp_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
    endtask

    task automatic wr(input int a, input logic [10:0] d);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = 8'(a);
        prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
        m_mem[a] = d;
        m_wr[a] = 1'b1;
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic run_go();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", busy, 0);
        run = 1'b0;
        step_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          end_pc;
        bit          halt;
        int          n;
        logic [10:0] w;

        reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        step_req = 1'b0; run = 1'b0; bp_en = 1'b0; bp_addr = '0;

        do_reset();
        check("rst_instruction", instruction, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_halted", halted, 0);
        check("rst_bp_hit", bp_hit, 0);

        // Single step of ADD at 0, then step+run together still acts as a step.
        wr(0, {3'd3, 8'($urandom)});
        wr(1, {3'd2, 8'($urandom)});
        clr_trace();
        step_pulse();
        wait_idle(20);
        exp_q = {0};
        check_trace("step0");
        check("step0_pc", pc, 1);
        check("step0_done_cnt", n_step_done, 1);
        check("step0_halted", halted, 0);
        clr_trace();
        @(negedge clk);
        step_req = 1'b1; run = 1'b1;
        @(negedge clk);
        step_req = 1'b0; run = 1'b0;
        wait_idle(20);
        exp_q = {1};
        check_trace("step1");
        check("step1_pc", pc, 2);
        check("step1_done_cnt", n_step_done, 1);
        check("step1_busy", busy, 0);

        // Four words then an unwritten one: run to HALT at pc 4; HALT is sticky.
        do_reset();
        for (int i = 0; i < 4; i++) wr(i, rand_word(1'b1));
        clr_trace();
        run_go();
        model_run(0, -1, end_pc, halt);
        wait_idle(100);
        check_trace("run4");
        check("run4_pc", pc, end_pc);
        check("run4_halted", halted, halt);
        step_pulse();
        repeat (3) @(negedge clk);
        check("halt_sticky", halted, 1);
        check("halt_not_busy", busy, 0);
        check("halt_pc", pc, end_pc);

        // Randomized programs with unwritten and illegal words.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) != 0) wr(i, rand_word($urandom_range(0, 4) != 0));
            end
            clr_trace();
            run_go();
            model_run(0, -1, end_pc, halt);
            wait_idle(200);
            check_trace("rand");
            check("rand_pc", pc, end_pc);
            check("rand_halted", halted, halt);
        end

        // Drop run mid-EXEC; step_req and program writes while busy are ignored.
        do_reset();
        for (int i = 0; i < 4; i++) wr(i, rand_word(1'b1));
        clr_trace();
        run_go();
        n = 0;
        while (!instr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("drop_valid_seen", instr_valid, 1);
        @(negedge clk);
        run = 1'b0; step_req = 1'b1;
        prog_we = 1'b1; prog_addr = 8'd1; prog_wdata = rand_word(1'b0);
        @(negedge clk);
        step_req = 1'b0; prog_we = 1'b0;
        wait_idle(20);
        exp_q = {0};
        check_trace("drop");
        check("drop_pc", pc, 1);
        check("drop_halted", halted, 0);
        check("drop_step_done", n_step_done, 0);
        clr_trace();
        run_go();
        model_run(1, -1, end_pc, halt);
        wait_idle(100);
        check_trace("resume");
        check("resume_pc", pc, end_pc);
        check("resume_halted", halted, halt);

        // Full program: HALT after address 255 with pc wrapped to 0.
        do_reset();
        for (int i = 0; i < 256; i++) wr(i, rand_word(1'b1));
        clr_trace();
        run_go();
        model_run(0, -1, end_pc, halt);
        wait_idle(256 * 5);
        check_trace("full");
        check("full_pc", pc, end_pc);
        check("full_halted", halted, halt);

        // Reset in the middle of EXEC.
        do_reset();
        wr(0, rand_word(1'b1));
        clr_trace();
        step_pulse();
        n = 0;
        while (!instr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mid_valid_seen", instr_valid, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_instr_valid", instr_valid, 0);
        check("mid_rst_instruction", instruction, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_step_done", step_done, 0);
        check("mid_rst_bp_hit", bp_hit, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
        clr_trace();
        step_pulse();
        model_run(0, -1, end_pc, halt);
        wait_idle(20);
        check_trace("postrst");
        check("postrst_halted", halted, halt);
        check("postrst_pc", pc, end_pc);
        check("postrst_instruction", instruction, 0);

        // Breakpoint at address 2.
        do_reset();
        for (int i = 0; i < 5; i++) wr(i, rand_word(1'b1));
        bp_addr = 8'd2;
        bp_en = 1'b1;
        clr_trace();
`ifdef SEQ_BREAKPOINT_EN
        model_run(0, 2, end_pc, halt);
        run_go();
        wait_idle(100);
        check_trace("bp_run");
        check("bp_hit_cnt", n_bp_hit, 1);
        check("bp_pc", pc, end_pc);
        check("bp_halted", halted, halt);
        clr_trace();
        step_pulse();
        wait_idle(20);
        exp_q = {2};
        check_trace("bp_step");
        check("bp_step_pc", pc, 3);
        check("bp_step_done", n_step_done, 1);
        check("bp_step_hit_cnt", n_bp_hit, 0);
`else
        model_run(0, -1, end_pc, halt);
        run_go();
        wait_idle(100);
        check_trace("nobp_run");
        check("nobp_hit_cnt", n_bp_hit, 0);
        check("nobp_pc", pc, end_pc);
        check("nobp_halted", halted, halt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 3: clock cycles each instruction is held stable for cpu_top.
REQ-002 SHALL have parameter PROG_DEPTH, default 256: program words; PC width is log2(PROG_DEPTH).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports prog_we / prog_addr / prog_wdata, input, 1 / 8 / 11: program load write strobe, address and word.
REQ-006 SHALL have ports step_req / run, input, 1 / 1: single-step pulse and free-run level.
REQ-007 SHALL have ports bp_en / bp_addr, input, 1 / 8: breakpoint enable and address.
REQ-008 SHALL have port instruction, output, 11: instruction driven to cpu_top.
REQ-009 SHALL have ports instr_valid / pc, output, 1 / 8: instruction currently executing; address of that instruction.
REQ-010 SHALL have ports busy / step_done / halted / bp_hit, output, 1 each: sequencer status flags.

Function
REQ-011 SHALL implement states IDLE, FETCH, EXEC, HALT.
REQ-012 SHALL keep a per-word written bit alongside the program memory, set on every accepted write.
REQ-013 SHALL accept prog_we only in IDLE or HALT; writes in FETCH or EXEC are dropped.
REQ-014 SHALL, in IDLE, go to FETCH on step_req=1 or run=1; step_req SHALL take priority when both are set.
REQ-015 SHALL, in FETCH (1 cycle), read the word at pc into instruction.
REQ-016 SHALL go to HALT from FETCH, with instruction unchanged, when the word at pc is unwritten or its opcode matches no OPC_* code.
REQ-017 SHALL, in EXEC, hold instr_valid=1 and instruction stable for exactly EXEC_CYCLES cycles, tracked by a down-counter.
REQ-018 SHALL, on the last EXEC cycle, increment pc modulo PROG_DEPTH.
REQ-019 SHALL go to HALT after the instruction at PROG_DEPTH-1 completes, with pc wrapped to 0.
REQ-020 SHALL, after EXEC, assert step_done for 1 cycle when started by step_req, then return to IDLE.
REQ-021 SHALL, after EXEC in run mode, go to FETCH if run=1, otherwise to IDLE.
REQ-022 SHALL ignore step_req while busy.
REQ-023 SHALL drive busy=1 in FETCH and EXEC only.
REQ-024 SHALL drive halted=1 in HALT; HALT is left only by reset.
REQ-025 SHALL NOT let a run or step_req deassertion during EXEC truncate the instruction in progress.

Reset
REQ-026 SHALL, while reset_n=0 at a clock edge, set state IDLE, pc=0, instruction=0, all status outputs 0, and the counter to 0.
REQ-027 SHALL clear all written bits on reset.
REQ-028 SHALL NOT require memory contents to be reset.
REQ-029 SHALL abort a mid-EXEC instruction on reset, with instr_valid=0 on the next cycle.

Configuration
REQ-030 SHALL, with SEQ_BREAKPOINT_EN defined, have FETCH in run mode with bp_en=1 and pc==bp_addr go to IDLE without executing and pulse bp_hit for 1 cycle.
REQ-031 SHALL NOT apply breakpoint checks to single-steps, so a step from the breakpoint address proceeds.
REQ-032 SHALL, without SEQ_BREAKPOINT_EN, ignore bp_en and bp_addr and tie bp_hit to 0.

Structure
REQ-033 SHALL take OPC_* codes, GET_OPCODE/GET_OP1/GET_OP2 and the 11-bit instruction width from the shared cpu_defs package.
REQ-034 SHALL define the state encoding and EXEC_CYCLES default in cpu_defs.
REQ-035 SHALL have one sub-module, seq_prog_mem: a synchronous-read 256x11 array with written-bit array and reset clear.

Verification
REQ-036 SHALL verify: load ADD (addr 0) and STO (addr 1), pulse step_req -> instr_valid high 3 cycles, pc 0->1, one step_done pulse.
REQ-037 SHALL verify: load words 0..3, leave word 4 unwritten, hold run=1 -> 4 instructions of 3 cycles each, then HALT with pc=4 and halted=1.
REQ-038 SHALL verify: drop run during the 2nd EXEC cycle -> instruction completes, pc advances, then IDLE.
REQ-039 SHALL verify: write all 256 words, run -> HALT after addr 255 with pc=0.
REQ-040 SHALL verify: assert reset_n=0 in mid-EXEC -> next cycle all outputs 0, and fetching any address halts.
REQ-041 SHALL verify, with SEQ_BREAKPOINT_EN: bp_addr=2, bp_en=1, run -> addrs 0 and 1 execute, bp_hit pulses, IDLE at pc=2; then step_req executes addr 2.
